cache_miss_sequencer: RTL and testbench

//  Multi-cycle sequencer for the single-port data cache and word-wide data memory.

---
 rtl/cache_seq_pkg.sv | 22 ++
 rtl/latency_counter.sv | 32 +++
 rtl/cache_miss_sequencer.sv | 170 +++++++++++++++++
 tb/tb_cache_miss_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_seq_pkg.sv
// Shared types and helpers for the data-cache miss sequencer.
//   seq_state_e   : sequencer FSM states
//   CACHE_IN_MEM  : cache data-in mux selects memory read data (line fill)
//   CACHE_IN_CORE : cache data-in mux selects store data from rt
//   word_align()  : clears the byte-offset bits of an address
package cache_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WB     = 2'd1,
        S_REFILL = 2'd2,
        S_FILL   = 2'd3
    } seq_state_e;

    localparam logic CACHE_IN_MEM  = 1'b0;
    localparam logic CACHE_IN_CORE = 1'b1;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/latency_counter.sv
// Loadable down-counter timing one memory access phase.
// Ports:
//   clk, rst_b  : clock, asynchronous active-low reset
//   load        : load load_value this cycle (takes priority over counting)
//   load_value  : value loaded into the counter
//   zero        : counter currently holds zero (phase complete)
// The counter decrements every cycle while non-zero and parks at zero.
module latency_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (count_q != '0) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/cache_miss_sequencer.sv
// Multi-cycle miss sequencer between the decode controller, the single-port
// data cache, the memory address mux and the pc_controller. On a miss it
// stalls the PC, writes back a dirty victim, refills the line, fills the
// cache and then lets the access replay as a hit.
// Ports:
//   clk, rst_b        : clock, asynchronous active-low reset
//   req_valid/write   : load/store issued this cycle (write=1 store)
//   req_addr          : data address from the ALU
//   halted            : core halted, no new miss is accepted
//   cache_hit/dirty   : cache lookup result for req_addr / indexed line
//   victim_addr       : address of the line to write back
//   stall             : hold PC and register writes
//   mem_addr          : word-aligned memory address
//   mem_write_en      : memory write strobe
//   cache_we          : cache line write enable
//   cache_in_sel      : CACHE_IN_MEM fill data / CACHE_IN_CORE store data
//   set_valid/dirty   : line status written with cache_we
//   seq_state         : current FSM state (debug observation)
//   hit_cnt/miss_cnt/wb_cnt : saturating event counters, present only when
//                             the MISS_STATS_EN macro is defined
// Request semantics: req_valid qualifies req_write/req_addr in the same
// cycle; there is no ready. A missing access is simply re-presented by the
// core while stall is high and is sampled only in the detect cycle.
module cache_miss_sequencer
    import cache_seq_pkg::*;
#(
    parameter int MEM_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic        halted,
    input  logic        cache_hit,
    input  logic        cache_dirty,
    input  logic [31:0] victim_addr,
    output logic        stall,
    output logic [31:0] mem_addr,
    output logic        mem_write_en,
    output logic        cache_we,
    output logic        cache_in_sel,
    output logic        set_valid,
    output logic        set_dirty,
    output logic [1:0]  seq_state
`ifdef MISS_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt,
    output logic [31:0] wb_cnt
`endif
);

    localparam int             CW       = $clog2(MEM_LATENCY + 1);
    localparam logic [CW-1:0]  LAT_LOAD = CW'(MEM_LATENCY - 1);

    seq_state_e  state_q, state_d;
    logic [31:0] req_addr_q, victim_q;
    logic        cnt_load, cnt_zero;
    logic        req_hit, miss_det;

    logic        stall_c, mem_we_c, cache_we_c, in_sel_c, valid_c, dirty_c;
    logic [31:0] mem_addr_c;

    assign req_hit  = req_valid &  cache_hit & ~halted;
    assign miss_det = req_valid & ~cache_hit & ~halted;

    latency_counter #(.WIDTH(CW)) u_lat (
        .clk        (clk),
        .rst_b      (rst_b),
        .load       (cnt_load),
        .load_value (LAT_LOAD),
        .zero       (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= S_IDLE;
            req_addr_q <= '0;
            victim_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && miss_det) begin
                req_addr_q <= word_align(req_addr);
                victim_q   <= word_align(victim_addr);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_load   = 1'b0;
        stall_c    = 1'b0;
        mem_addr_c = word_align(req_addr);
        mem_we_c   = 1'b0;
        cache_we_c = 1'b0;
        in_sel_c   = CACHE_IN_MEM;
        valid_c    = 1'b0;
        dirty_c    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (miss_det) begin
                    stall_c  = 1'b1;
                    cnt_load = 1'b1;
                    state_d  = cache_dirty ? S_WB : S_REFILL;
                end else if (req_hit && req_write) begin
                    // Store hit (including the replay after a fill) dirties the line.
                    cache_we_c = 1'b1;
                    in_sel_c   = CACHE_IN_CORE;
                    valid_c    = 1'b1;
                    dirty_c    = 1'b1;
                end
            end
            S_WB: begin
                stall_c    = 1'b1;
                mem_addr_c = victim_q;
                mem_we_c   = 1'b1;
                if (cnt_zero) begin
                    cnt_load = 1'b1;
                    state_d  = S_REFILL;
                end
            end
            S_REFILL: begin
                stall_c    = 1'b1;
                mem_addr_c = req_addr_q;
                if (cnt_zero) begin
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                stall_c    = 1'b1;
                cache_we_c = 1'b1;
                in_sel_c   = CACHE_IN_MEM;
                valid_c    = 1'b1;
                dirty_c    = 1'b0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are forced low while reset is asserted so that no memory or
    // cache write strobe can escape during reset, even with a request present.
    assign stall        = rst_b & stall_c;
    assign mem_addr     = rst_b ? mem_addr_c : 32'h0;
    assign mem_write_en = rst_b & mem_we_c;
    assign cache_we     = rst_b & cache_we_c;
    assign cache_in_sel = rst_b & in_sel_c;
    assign set_valid    = rst_b & valid_c;
    assign set_dirty    = rst_b & dirty_c;
    assign seq_state    = state_q;

`ifdef MISS_STATS_EN
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            wb_cnt   <= '0;
        end else if (state_q == S_IDLE) begin
            if (req_hit && hit_cnt != 32'hFFFF_FFFF)
                hit_cnt <= hit_cnt + 32'd1;
            if (miss_det && miss_cnt != 32'hFFFF_FFFF)
                miss_cnt <= miss_cnt + 32'd1;
            if (state_d == S_WB && wb_cnt != 32'hFFFF_FFFF)
                wb_cnt <= wb_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_miss_sequencer.sv
// Self-checking bench for cache_miss_sequencer (MEM_LATENCY=4).
// Expected per-cycle outputs come from a behavioural model of a miss: a list
// of phases (detect, write-back, refill, fill, replay) built with plain
// arithmetic from the latency. Statistic checks compile in when
// MISS_STATS_EN is defined.
module tb_cache_miss_sequencer;
    import cache_seq_pkg::*;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        req_valid, req_write, halted, cache_hit, cache_dirty;
    logic [31:0] req_addr, victim_addr;
    logic        stall, mem_write_en, cache_we, cache_in_sel, set_valid, set_dirty;
    logic [31:0] mem_addr;
    logic [1:0]  seq_state;
`ifdef MISS_STATS_EN
    logic [31:0] hit_cnt, miss_cnt, wb_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [37:0] exp_q[$];
    logic [37:0] obs;

    cache_miss_sequencer #(.MEM_LATENCY(L)) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .halted       (halted),
        .cache_hit    (cache_hit),
        .cache_dirty  (cache_dirty),
        .victim_addr  (victim_addr),
        .stall        (stall),
        .mem_addr     (mem_addr),
        .mem_write_en (mem_write_en),
        .cache_we     (cache_we),
        .cache_in_sel (cache_in_sel),
        .set_valid    (set_valid),
        .set_dirty    (set_dirty),
        .seq_state    (seq_state)
`ifdef MISS_STATS_EN
        ,
        .hit_cnt      (hit_cnt),
        .miss_cnt     (miss_cnt),
        .wb_cnt       (wb_cnt)
`endif
    );

    // ---------------- clock / observation ----------------
    always #5 clk = ~clk;

    assign obs = {stall, mem_addr, mem_write_en, cache_we, cache_in_sel, set_valid, set_dirty};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model helpers ----------------
    function automatic logic [37:0] pack(input logic s, input logic [31:0] a, input logic we,
                                         input logic cwe, input logic sel, input logic v, input logic d);
        return {s, a, we, cwe, sel, v, d};
    endfunction

    function automatic logic [31:0] align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

    // Expected trace of one miss: detect, L write-back cycles if dirty,
    // L refill cycles, one fill cycle, then the replay hit.
    task automatic model_miss(input logic wr, input logic [31:0] addr, input logic dirty,
                              input logic [31:0] victim);
        exp_q.delete();
        exp_q.push_back(pack(1'b1, align(addr), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        if (dirty)
            repeat (L) exp_q.push_back(pack(1'b1, align(victim), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        repeat (L) exp_q.push_back(pack(1'b1, align(addr), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(pack(1'b1, align(addr), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
        if (wr) exp_q.push_back(pack(1'b0, align(addr), 1'b0, 1'b1, 1'b1, 1'b1, 1'b1));
        else    exp_q.push_back(pack(1'b0, align(addr), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic w, input logic [31:0] a, input logic hit,
                         input logic d, input logic [31:0] vic, input logic h);
        req_valid   = v;
        req_write   = w;
        req_addr    = a;
        cache_hit   = hit;
        cache_dirty = d;
        victim_addr = vic;
        halted      = h;
    endtask

    task automatic drive_idle();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    // Entered and left at posedge+1. junk: 0 hold request, 1 random inputs
    // during the memory phases, 2 drop req_valid and move req_addr to 0x999
    // during the refill phase.
    task automatic run_miss(input logic wr, input logic [31:0] addr, input logic dirty,
                            input logic [31:0] victim, input int junk, input string tag);
        int n_mem;
        int total;
        int stall_cycles;
        logic [37:0] exp;
        n_mem = dirty ? 2 * L : L;
        total = n_mem + 3;
        stall_cycles = 0;
        model_miss(wr, addr, dirty, victim);
        for (int c = 0; c < total; c++) begin
            if (c == 0) begin
                drive(1'b1, wr, addr, 1'b0, dirty, victim, 1'b0);
            end else if (c <= n_mem) begin
                if (junk == 1)
                    drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          align($urandom), 1'($urandom_range(0, 1)));
                else if (junk == 2 && c > n_mem - L)
                    drive(1'b0, wr, 32'h999, 1'b0, dirty, victim, 1'b0);
                else
                    drive(1'b1, wr, addr, 1'b0, dirty, victim, 1'b0);
            end else if (c == n_mem + 1) begin
                drive(1'b1, wr, addr, 1'b0, 1'b0, victim, 1'b0);
            end else begin
                drive(1'b1, wr, addr, 1'b1, 1'b0, victim, 1'b0);
            end
            @(negedge clk);
            exp = exp_q.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL %s cycle %0d: got %h expected %h", tag, c, obs, exp);
            end
            if (stall === 1'b1) stall_cycles++;
            @(posedge clk); #1;
        end
        checks++;
        if (stall_cycles != (dirty ? 2 * L + 2 : L + 2)) begin
            errors++;
            $display("FAIL %s stall_cycles: got %0d expected %0d", tag, stall_cycles,
                     dirty ? 2 * L + 2 : L + 2);
        end
        drive_idle();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_b = 1'b0;
        drive(1'b1, 1'b1, 32'h1234, 1'b1, 1'b1, 32'h5678, 1'b0);
        #2;
        checks++;
        if (obs !== 38'h0 || seq_state !== S_IDLE) begin
            errors++;
            $display("FAIL reset_outputs: got %h state %0d expected 0 state 0", obs, seq_state);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (mem_write_en !== 1'b0 || cache_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_write: got we=%b cwe=%b expected 0 0", mem_write_en, cache_we);
        end
`ifdef MISS_STATS_EN
        checks++;
        if (hit_cnt !== 32'h0 || miss_cnt !== 32'h0 || wb_cnt !== 32'h0) begin
            errors++;
            $display("FAIL reset_stats: got %0d %0d %0d expected 0 0 0", hit_cnt, miss_cnt, wb_cnt);
        end
`endif
        drive_idle();
        @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_hits();
        drive(1'b1, 1'b0, 32'h100, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        checks++;
        if (obs !== pack(1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL load_hit: got %h expected %h", obs, pack(1'b0, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        @(posedge clk); #1;
        checks++;
        if (seq_state !== S_IDLE) begin
            errors++;
            $display("FAIL load_hit_state: got %0d expected %0d", seq_state, S_IDLE);
        end
        drive(1'b1, 1'b1, 32'h107, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        checks++;
        if (obs !== pack(1'b0, 32'h104, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1)) begin
            errors++;
            $display("FAIL store_hit: got %h expected %h", obs, pack(1'b0, 32'h104, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1));
        end
        @(posedge clk); #1;
        drive_idle();
    endtask

    task automatic test_clean_load_miss();
        run_miss(1'b0, 32'h204, 1'b0, 32'h0, 0, "clean_load_miss");
    endtask

    task automatic test_dirty_store_miss();
`ifdef MISS_STATS_EN
        logic [31:0] h0, m0, w0;
        h0 = hit_cnt; m0 = miss_cnt; w0 = wb_cnt;
`endif
        run_miss(1'b1, 32'h300, 1'b1, 32'h700, 0, "dirty_store_miss");
`ifdef MISS_STATS_EN
        checks++;
        if (hit_cnt !== h0 + 1 || miss_cnt !== m0 + 1 || wb_cnt !== w0 + 1) begin
            errors++;
            $display("FAIL stats_dirty_miss: got %0d %0d %0d expected %0d %0d %0d",
                     hit_cnt, miss_cnt, wb_cnt, h0 + 1, m0 + 1, w0 + 1);
        end
`endif
    endtask

    task automatic test_reset_mid_wb();
        drive(1'b1, 1'b0, 32'h400, 1'b0, 1'b1, 32'h800, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (mem_write_en !== 1'b1 || mem_addr !== 32'h800) begin
            errors++;
            $display("FAIL mid_wb_before_reset: got we=%b addr=%h expected 1 00000800", mem_write_en, mem_addr);
        end
        rst_b = 1'b0;
        #1;
        checks++;
        if (obs !== 38'h0 || seq_state !== S_IDLE) begin
            errors++;
            $display("FAIL mid_wb_reset: got %h state %0d expected 0 state 0", obs, seq_state);
        end
        drive_idle();
        @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 2 * L + 2; c++) begin
            @(negedge clk);
            checks++;
            if (mem_write_en !== 1'b0 || stall !== 1'b0 || seq_state !== S_IDLE) begin
                errors++;
                $display("FAIL after_reset cycle %0d: got we=%b stall=%b state=%0d expected 0 0 0",
                         c, mem_write_en, stall, seq_state);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_refill_addr_change();
        run_miss(1'b0, 32'h604, 1'b0, 32'h0, 2, "refill_addr_change");
        run_miss(1'b1, 32'h60C, 1'b1, 32'hA00, 2, "refill_addr_change_dirty");
    endtask

    task automatic test_halted();
`ifdef MISS_STATS_EN
        logic [31:0] m0;
        m0 = miss_cnt;
`endif
        drive(1'b1, 1'b0, 32'h880, 1'b0, 1'b1, 32'h900, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== pack(1'b0, 32'h880, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)) begin
                errors++;
                $display("FAIL halted_miss cycle %0d: got %h expected %h", c, obs,
                         pack(1'b0, 32'h880, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
            end
            @(posedge clk); #1;
            checks++;
            if (seq_state !== S_IDLE) begin
                errors++;
                $display("FAIL halted_state cycle %0d: got %0d expected %0d", c, seq_state, S_IDLE);
            end
        end
`ifdef MISS_STATS_EN
        checks++;
        if (miss_cnt !== m0) begin
            errors++;
            $display("FAIL halted_miss_cnt: got %0d expected %0d", miss_cnt, m0);
        end
`endif
        drive_idle();
    endtask

    task automatic test_random();
        logic        wr;
        logic [31:0] addr;
        logic [37:0] exp;
        for (int i = 0; i < 24; i++) begin
            wr   = 1'($urandom_range(0, 1));
            addr = $urandom;
            if ($urandom_range(0, 2) == 0) begin
                drive(1'b1, wr, addr, 1'b1, 1'($urandom_range(0, 1)), $urandom, 1'b0);
                exp = wr ? pack(1'b0, align(addr), 1'b0, 1'b1, 1'b1, 1'b1, 1'b1)
                         : pack(1'b0, align(addr), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                @(negedge clk);
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL random_hit %0d: got %h expected %h", i, obs, exp);
                end
                @(posedge clk); #1;
                drive_idle();
            end else begin
                run_miss(wr, addr, 1'($urandom_range(0, 1)), align($urandom),
                         int'($urandom_range(0, 2)), "random_miss");
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_hits();
        test_clean_load_miss();
        test_dirty_store_miss();
        test_reset_mid_wb();
        test_refill_addr_change();
        test_halted();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
